a51_keystream_gen: RTL and testbench

- Complete A5/1 keystream generator for the image-encryption datapath.
- Holds three parametrised LFSRs and performs key/frame mixing, majority-clocked warm-up, and packing of keystream bits into OUT_W-bit words.
- Words go out on a valid/ready stream that is XORed with pixel data downstream.
- Replaces per-register instantiation with a single sequenced block that supports stall, abort and re-keying.

---
 rtl/a51_pkg.sv | 33 +++
 rtl/a51_keystream_gen_lfsr.sv | 40 ++++
 rtl/a51_keystream_gen.sv | 181 ++++++++++++++++++
 tb/tb_a51_keystream_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/a51_pkg.sv
// Shared constants and types for the A5/1 keystream generator.
// Register geometry, tap masks, clocking bits and FSM states.
package a51_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  typedef enum logic [2:0] {
    IDLE,
    KEY_MIX,
    FRAME_MIX,
    WARMUP,
    RUN
  } state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_keystream_gen_lfsr.sv
// One A5/1 shift register: shifts left, feedback (taps ^ inject) enters bit 0.
// Clear has priority over step.
module a51_lfsr #(
  parameter int               WIDTH    = 19,
  parameter logic [WIDTH-1:0] TAP_MASK = '0,
  parameter int               CLK_BIT  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic step,
  input  logic inject,
  output logic msb,
  output logic clk_bit
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  always_comb begin
    r_d = r_q;
    if (clear) begin
      r_d = '0;
    end else if (step) begin
      r_d = {r_q[WIDTH-2:0], (^(r_q & TAP_MASK)) ^ inject};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign msb     = r_q[WIDTH-1];
  assign clk_bit = r_q[CLK_BIT];

endmodule

// File: rtl/a51_keystream_gen.sv
// A5/1 keystream generator: key/frame mixing, majority warm-up,
// and packing of keystream bits into words on a valid/ready stream.
module a51_keystream_gen
  import a51_pkg::*;
#(
  parameter int KEY_BITS      = 64,
  parameter int FRAME_BITS    = 22,
  parameter int WARMUP_CYCLES = 100,
  parameter int OUT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [KEY_BITS-1:0]   key,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  busy,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic [OUT_W-1:0]      ks_data
);

  localparam int CNT_MAX =
    (KEY_BITS > FRAME_BITS)
      ? ((KEY_BITS > WARMUP_CYCLES) ? KEY_BITS : WARMUP_CYCLES)
      : ((FRAME_BITS > WARMUP_CYCLES) ? FRAME_BITS : WARMUP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int BIT_W = $clog2(OUT_W + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bcnt_q, bcnt_d;
  logic [OUT_W-1:0] pack_q, pack_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic clr, step_all, step_maj, inj;
  logic m1, m2, m3, c1, c2, c3;
  logic maj, obit, stall, accept;
  logic key_bit, frame_bit;
  logic [OUT_W-1:0] shifted;

  a51_lfsr #(.WIDTH(R1_LEN), .TAP_MASK(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .clk(clk), .rst(rst), .clear(clr),
    .step(step_all | (step_maj & (c1 == maj))),
    .inject(inj), .msb(m1), .clk_bit(c1)
  );

  a51_lfsr #(.WIDTH(R2_LEN), .TAP_MASK(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .clk(clk), .rst(rst), .clear(clr),
    .step(step_all | (step_maj & (c2 == maj))),
    .inject(inj), .msb(m2), .clk_bit(c2)
  );

  a51_lfsr #(.WIDTH(R3_LEN), .TAP_MASK(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .clk(clk), .rst(rst), .clear(clr),
    .step(step_all | (step_maj & (c3 == maj))),
    .inject(inj), .msb(m3), .clk_bit(c3)
  );

  assign maj     = maj3(c1, c2, c3);
  assign obit    = m1 ^ m2 ^ m3;
  assign stall   = valid_q & ~ks_ready;
  assign accept  = valid_q & ks_ready;
  assign shifted = (pack_q << 1) | OUT_W'(obit);

  always_comb begin
    key_bit = 1'b0;
    for (int i = 0; i < KEY_BITS; i++) begin
      if (cnt_q == CNT_W'(i)) key_bit = key[i];
    end
  end

  always_comb begin
    frame_bit = 1'b0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (cnt_q == CNT_W'(i)) frame_bit = frame[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    pack_d   = pack_q;
    data_d   = data_q;
    valid_d  = valid_q;
    clr      = 1'b0;
    step_all = 1'b0;
    step_maj = 1'b0;
    inj      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          cnt_d   = '0;
          bcnt_d  = '0;
          pack_d  = '0;
          state_d = KEY_MIX;
        end
      end
      KEY_MIX: begin
        step_all = 1'b1;
        inj      = key_bit;
        if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
          cnt_d   = '0;
          state_d = FRAME_MIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FRAME_MIX: begin
        step_all = 1'b1;
        inj      = frame_bit;
        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
          cnt_d   = '0;
          state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WARMUP: begin
        step_maj = 1'b1;
        if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (accept) valid_d = 1'b0;
        if (!stall) begin
          step_maj = 1'b1;
          pack_d   = shifted;
          if (bcnt_q == BIT_W'(OUT_W - 1)) begin
            bcnt_d  = '0;
            data_d  = shifted;
            valid_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort freezes the LFSRs where they are and drops any pending word.
    if (stop && state_q != IDLE) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      step_all = 1'b0;
      step_maj = 1'b0;
      pack_d   = pack_q;
      bcnt_d   = bcnt_q;
      data_d   = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign ks_valid = valid_q;
  assign ks_data  = data_q;

endmodule

// File: tb/tb_a51_keystream_gen.sv
// Directed bench for a51_keystream_gen with an independent bit-level
// A5/1 reference model.
module tb_a51_keystream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [63:0] key;
  logic [21:0] frame;
  logic        busy;
  logic        ks_valid;
  logic        ks_ready;
  logic [7:0]  ks_data;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_w [16];
  logic [7:0] got_w [16];
  int         got_c [16];

  logic [18:0] ma;
  logic [21:0] mb;
  logic [22:0] mc;

  a51_keystream_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .key(key), .frame(frame), .busy(busy),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] sh1(logic [18:0] a, logic i);
    return {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ i};
  endfunction
  function automatic logic [21:0] sh2(logic [21:0] b, logic i);
    return {b[20:0], b[21] ^ b[20] ^ i};
  endfunction
  function automatic logic [22:0] sh3(logic [22:0] c, logic i);
    return {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ i};
  endfunction

  task automatic maj_step();
    logic m;
    m = (ma[8] & mb[10]) | (ma[8] & mc[10]) | (mb[10] & mc[10]);
    if (ma[8] == m) ma = sh1(ma, 1'b0);
    if (mb[10] == m) mb = sh2(mb, 1'b0);
    if (mc[10] == m) mc = sh3(mc, 1'b0);
  endtask

  task automatic model_gen(input logic [63:0] k, input logic [21:0] f);
    logic [7:0] w;
    ma = '0; mb = '0; mc = '0;
    for (int i = 0; i < 64; i++) begin
      ma = sh1(ma, k[i]); mb = sh2(mb, k[i]); mc = sh3(mc, k[i]);
    end
    for (int i = 0; i < 22; i++) begin
      ma = sh1(ma, f[i]); mb = sh2(mb, f[i]); mc = sh3(mc, f[i]);
    end
    for (int i = 0; i < 100; i++) maj_step();
    for (int wi = 0; wi < 16; wi++) begin
      w = '0;
      for (int bi = 0; bi < 8; bi++) begin
        w = {w[6:0], ma[18] ^ mb[21] ^ mc[22]};
        maj_step();
      end
      exp_w[wi] = w;
    end
  endtask

  task automatic start_wait(input int extra_at, output int n);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while (!ks_valid && n < 400) begin
      start = (n == extra_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic collect(input int nw, input int stall_word,
                         input string tag);
    int idx;
    int cyc;
    logic [7:0] held;
    idx = 0;
    cyc = 0;
    while (idx < nw && cyc < 3000) begin
      if (ks_valid) begin
        if (idx == stall_word) begin
          ks_ready = 1'b0;
          held = ks_data;
          for (int s = 0; s < 20; s++) begin
            @(negedge clk); cyc++;
            chk("stall_hold", {ks_valid, ks_data}, {1'b1, held});
          end
          ks_ready = 1'b1;
        end
        got_w[idx] = ks_data;
        got_c[idx] = cyc;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_count"}, 64'(idx), 64'(nw));
  endtask

  task automatic do_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    key = '0; frame = '0; ks_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(ks_valid), 64'd0);
    chk("rst_data", 64'(ks_data), 64'd0);
    rst = 1'b0;

    start_wait(0, n);
    chk("zero_latency", 64'(n), 64'd195);
    collect(4, -1, "zero");
    for (int i = 0; i < 4; i++) chk("zero_word", 64'(got_w[i]), 64'd0);
    for (int i = 1; i < 4; i++)
      chk("zero_spacing", 64'(got_c[i] - got_c[i-1]), 64'd8);
    do_stop();

    key = 64'h1223456789ABCDEF;
    frame = 22'h134;
    model_gen(key, frame);
    start_wait(0, n);
    chk("gold_latency", 64'(n), 64'd195);
    collect(16, -1, "gold");
    for (int i = 0; i < 16; i++) chk("gold_word", 64'(got_w[i]), 64'(exp_w[i]));
    do_stop();

    start_wait(0, n);
    collect(16, 3, "stall");
    for (int i = 0; i < 16; i++) chk("stall_word", 64'(got_w[i]), 64'(exp_w[i]));
    do_stop();

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while (n < 120) begin
      @(negedge clk);
      n++;
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_valid", 64'(ks_valid), 64'd0);
    start_wait(0, n);
    chk("restart_latency", 64'(n), 64'd195);
    chk("restart_word0", 64'(ks_data), 64'(exp_w[0]));
    do_stop();

    start_wait(0, n);
    chk("pre_rst_valid", 64'(ks_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(ks_valid), 64'd0);
    chk("midrst_data", 64'(ks_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ks_valid || busy) seen++;
    end
    chk("post_rst_quiet", 64'(seen), 64'd0);

    start_wait(10, n);
    chk("restart_ignored_latency", 64'(n), 64'd195);
    collect(4, -1, "dup");
    for (int i = 0; i < 4; i++) chk("dup_word", 64'(got_w[i]), 64'(exp_w[i]));
    do_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
